conv_stream_param: RTL and testbench

CONV_STREAM_PARAM -- requirements
Module: conv_stream_param

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_line_buffer.sv | 19 +
 rtl/conv_stream_param.sv | 124 ++++++++++++
 tb/tb_conv_stream_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: FSM state encoding, default convolution parameters and accumulator width helper
package conv_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, CONV = 3'd2, DONE = 3'd3} state_t;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_KERNEL = 5;
  localparam int DEF_NUM_FMAPS = 6;
  localparam int DEF_STRIDE = 1;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_OUT_W = 16;
  function automatic int acc_width(input int data_w, input int weight_w, input int kernel);
    return data_w + weight_w + 1 + $clog2(kernel * kernel + 1);
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-entry shift RAM of W-bit words (clk, en shifts din in, dout is the word DEPTH shifts old)
module conv_line_buffer #(
  parameter int W = 8,
  parameter int DEPTH = 28
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv_stream_param.sv
// conv_stream_param: streaming KxK multi-channel convolution (weight write bus, valid/ready pixel in, valid/ready/last features out, debug col/row/state)
module conv_stream_param
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int KERNEL = DEF_KERNEL,
  parameter int NUM_FMAPS = DEF_NUM_FMAPS,
  parameter int STRIDE = DEF_STRIDE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_weight_wr,
  input  logic [$clog2(NUM_FMAPS*(KERNEL*KERNEL+1))-1:0] i_weight_addr,
  input  logic signed [WEIGHT_W-1:0]                    i_weight_data,
  input  logic                                          i_feature_valid,
  input  logic [DATA_W-1:0]                             i_feature,
  output logic                                          o_ready_feature,
  input  logic                                          i_out_ready,
  output logic                                          o_feature_valid,
  output logic signed [OUT_W-1:0]                       o_features [NUM_FMAPS],
  output logic                                          o_last_feature,
  output logic [10:0]                                   debug_conv_col,
  output logic [10:0]                                   debug_conv_row,
  output logic [2:0]                                    debug_state
);
  localparam int KK = KERNEL * KERNEL;
  localparam int NW = NUM_FMAPS * (KK + 1);
  localparam int PW = DATA_W + WEIGHT_W + 1;
  localparam int AW = acc_width(DATA_W, WEIGHT_W, KERNEL);
  localparam int LR = ((IMG_H - KERNEL) / STRIDE) * STRIDE;
  localparam int LC = ((IMG_W - KERNEL) / STRIDE) * STRIDE;
  localparam logic [10:0] CMAX = 11'(IMG_W - 1);
  localparam logic [10:0] RMAX = 11'(IMG_H - 1);
  localparam logic [10:0] KM1 = 11'(KERNEL - 1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  state_t st;
  logic [10:0] col, row;
  logic signed [WEIGHT_W-1:0] wmem [NW];
  logic [DATA_W-1:0] lb_in [KERNEL-1];
  logic [DATA_W-1:0] lb_out [KERNEL-1];
  logic [DATA_W-1:0] col_in [KERNEL];
  logic [DATA_W-1:0] win [KERNEL][KERNEL];
  logic [DATA_W-1:0] wn [KERNEL][KERNEL];
  logic signed [PW-1:0] prod [NUM_FMAPS][KK];
  logic signed [PW-1:0] pr [NUM_FMAPS][KK];
  logic signed [AW-1:0] sum [NUM_FMAPS];
  logic signed [OUT_W-1:0] sat [NUM_FMAPS];
  logic adv, acc, gen, last, p_valid, p_last;
  int ri, ci;
  assign adv = !o_feature_valid || i_out_ready;
  assign o_ready_feature = !i_rst && st != DONE && adv;
  assign acc = i_feature_valid && o_ready_feature;
  assign debug_conv_col = col;
  assign debug_conv_row = row;
  assign debug_state = st;
  for (genvar g = 0; g < KERNEL - 1; g++) begin : g_lb
    conv_line_buffer #(.W(DATA_W), .DEPTH(IMG_W)) u_lb (.clk(i_clk), .en(acc), .din(lb_in[g]), .dout(lb_out[g]));
  end
  always_comb begin
    lb_in[0] = i_feature;
    for (int i = 1; i < KERNEL - 1; i++) lb_in[i] = lb_out[i-1];
    col_in[KERNEL-1] = i_feature;
    for (int k = 0; k < KERNEL - 1; k++) col_in[k] = lb_out[KERNEL-2-k];
    for (int k = 0; k < KERNEL; k++) begin
      wn[k][KERNEL-1] = col_in[k];
      for (int j = 0; j < KERNEL - 1; j++) wn[k][j] = win[k][j+1];
    end
    for (int f = 0; f < NUM_FMAPS; f++)
      for (int k = 0; k < KERNEL; k++)
        for (int j = 0; j < KERNEL; j++)
          prod[f][k*KERNEL+j] = PW'($signed({1'b0, wn[k][j]})) * PW'(wmem[f*(KK+1)+k*KERNEL+j]);
  end
  always_comb begin
    ri = int'(row) - (KERNEL - 1);
    ci = int'(col) - (KERNEL - 1);
    gen = ri >= 0 && ci >= 0 && ri % STRIDE == 0 && ci % STRIDE == 0;
    last = gen && ri == LR && ci == LC;
    for (int f = 0; f < NUM_FMAPS; f++) begin
      sum[f] = AW'(wmem[f*(KK+1)+KK]);
      for (int i = 0; i < KK; i++) sum[f] = sum[f] + AW'(pr[f][i]);
      sat[f] = sum[f] > SMAX ? SMAX[OUT_W-1:0] : sum[f] < SMIN ? SMIN[OUT_W-1:0] : sum[f][OUT_W-1:0];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_weight_wr && st == IDLE) wmem[i_weight_addr] <= i_weight_data;
    if (acc) begin
      win <= wn;
      pr <= prod;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
      col <= '0;
      row <= '0;
      p_valid <= 1'b0;
      p_last <= 1'b0;
      o_feature_valid <= 1'b0;
      o_last_feature <= 1'b0;
      for (int f = 0; f < NUM_FMAPS; f++) o_features[f] <= '0;
    end else begin
      if (acc) begin
        col <= col == CMAX ? '0 : col + 1'b1;
        row <= col != CMAX ? row : row == RMAX ? '0 : row + 1'b1;
        p_valid <= gen;
        p_last <= last;
      end else if (adv) p_valid <= 1'b0;
      if (adv) begin
        o_feature_valid <= p_valid;
        o_last_feature <= p_valid && p_last;
        if (p_valid) o_features <= sat;
      end
      st <= (st == IDLE && acc) ? FILL :
            (st == FILL && acc && row == KM1 && col == KM1) ? CONV :
            (st == CONV && acc && row == RMAX && col == CMAX) ? DONE :
            (st == DONE && !p_valid && adv) ? IDLE : st;
    end
  end
endmodule

// File: tb/tb_conv_stream_param.sv
// tb_conv_stream_param: scoreboard bench for two 8x8 K=3 instances (stride 1 and stride 2)
module tb_conv_stream_param;
  import conv_pkg::*;
  localparam int W = 8;
  localparam int H = 8;
  localparam int K = 3;
  localparam int NF = 6;
  localparam int AWID = $clog2(NF * (K * K + 1));
  typedef struct packed {
    logic [NF-1:0][15:0] f;
    logic last;
    int cyc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic [1:0] fv = '0;
  logic [1:0] wr = '0;
  logic [1:0] ordy = 2'b11;
  logic [7:0] pix = '0;
  logic [AWID-1:0] waddr = '0;
  logic signed [7:0] wdata = '0;
  logic [1:0] rdy, ov, ol;
  logic signed [15:0] of0 [NF];
  logic signed [15:0] of1 [NF];
  logic [10:0] dcol [2];
  logic [10:0] drow [2];
  logic [2:0] dst [2];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int img [H][W];
  int wt [2][NF][10];
  exp_t q0[$];
  exp_t q1[$];
  int nout [2];
  int ngen [2];
  logic pres [2];
  logic check_lat = 0;

  conv_stream_param #(.IMG_W(W), .IMG_H(H), .KERNEL(K), .NUM_FMAPS(NF), .STRIDE(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_weight_wr(wr[0]), .i_weight_addr(waddr), .i_weight_data(wdata),
    .i_feature_valid(fv[0]), .i_feature(pix), .o_ready_feature(rdy[0]), .i_out_ready(ordy[0]),
    .o_feature_valid(ov[0]), .o_features(of0), .o_last_feature(ol[0]),
    .debug_conv_col(dcol[0]), .debug_conv_row(drow[0]), .debug_state(dst[0]));
  conv_stream_param #(.IMG_W(W), .IMG_H(H), .KERNEL(K), .NUM_FMAPS(NF), .STRIDE(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_weight_wr(wr[1]), .i_weight_addr(waddr), .i_weight_data(wdata),
    .i_feature_valid(fv[1]), .i_feature(pix), .o_ready_feature(rdy[1]), .i_out_ready(ordy[1]),
    .o_feature_valid(ov[1]), .o_features(of1), .o_last_feature(ol[1]),
    .debug_conv_col(dcol[1]), .debug_conv_row(drow[1]), .debug_state(dst[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int s, input int r, input int c);
    exp_t e;
    int a;
    e = '0;
    for (int f = 0; f < NF; f++) begin
      a = wt[s][f][9];
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          a += img[r-2+kr][c-2+kc] * wt[s][f][kr*K+kc];
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
      e.f[f] = a[15:0];
    end
    e.cyc = cyc;
    return e;
  endfunction

  task automatic wwrite(input int s, input int addr, input int data);
    wr[s] = 1;
    waddr = AWID'(addr);
    wdata = 8'(data);
    @(negedge clk);
    wr[s] = 0;
    wt[s][addr/10][addr%10] = data;
  endtask

  task automatic send(input int s, input int px, input int r, input int c);
    int t = 0;
    int sd = s ? 2 : 1;
    int tot = ((H - K) / sd + 1) * ((W - K) / sd + 1);
    exp_t e;
    pix = 8'(px);
    fv[s] = 1;
    #1;
    while (!rdy[s] && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!rdy[s]) chk("accept_timeout", rdy[s], 1);
    img[r][c] = px;
    if (r >= 2 && c >= 2 && (r - 2) % sd == 0 && (c - 2) % sd == 0) begin
      e = model(s, r, c);
      ngen[s]++;
      e.last = ngen[s] == tot;
      if (s == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk);
    fv[s] = 0;
  endtask

  task automatic frame(input int s, input int mode, input int gap, input bit wmid, input int npix);
    int n = 0;
    int px;
    ngen[s] = 0;
    nout[s] = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (n == npix) return;
        if (gap > 0 && $urandom_range(0, 99) < gap) repeat ($urandom_range(1, 3)) @(negedge clk);
        if (wmid && r >= 3 && $urandom_range(0, 5) == 0) begin
          wr[s] = 1;
          waddr = AWID'($urandom_range(0, NF * 10 - 1));
          wdata = 8'($urandom_range(0, 255));
        end
        px = mode == 0 ? 1 : mode == 1 ? 255 : mode == 2 ? int'($urandom_range(0, 255)) : r * W + c + 1;
        send(s, px, r, c);
        wr[s] = 0;
        n++;
      end
  endtask

  task automatic finish_frame(input int s, input int expn);
    int t = 0;
    while (((s ? q1.size() : q0.size()) != 0 || dst[s] != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("pending_outputs", s ? q1.size() : q0.size(), 0);
    chk("state_idle", dst[s], 0);
    chk("out_count", nout[s], expn);
  endtask

  task automatic random_weights(input int s);
    for (int a = 0; a < NF * 10; a++) wwrite(s, a, int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic mon(input int s);
    exp_t e;
    int n;
    logic signed [15:0] f [NF];
    if (!ov[s]) return;
    n = s ? q1.size() : q0.size();
    if (n == 0) begin
      chk("unexpected_output", n, 1);
      return;
    end
    e = s ? q1[0] : q0[0];
    for (int i = 0; i < NF; i++) f[i] = s ? of1[i] : of0[i];
    for (int i = 0; i < NF; i++) chk($sformatf("feature_s%0d_ch%0d", s, i), f[i], $signed(e.f[i]));
    chk("last_flag", ol[s], e.last);
    if (check_lat && !pres[s]) chk("latency", cyc - e.cyc, 2);
    pres[s] = 1;
    if (!ordy[s]) chk("ready_during_stall", rdy[s], 0);
    else begin
      if (s == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      nout[s]++;
      pres[s] = 0;
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    pres[0] = 0;
    pres[1] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", rdy[0], 0);
    chk("reset_ready_s2", rdy[1], 0);
    chk("reset_valid", ov[0], 0);
    chk("reset_last", ol[0], 0);
    chk("reset_features", of0[0], 0);
    chk("reset_state", dst[0], 0);
    chk("reset_col", dcol[0], 0);
    chk("reset_row", drow[0], 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("ready_after_release", rdy[0], 1);
    @(negedge clk);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < NF * 10; a++) wwrite(s, a, (a % 10 == 9) ? 0 : 1);
    check_lat = 1;
    frame(0, 0, 0, 0, 64);
    finish_frame(0, 36);
    check_lat = 0;
    for (int a = 0; a < NF * 10; a++) wwrite(0, a, ((a / 10) % 2 == 0) ? 127 : -128);
    frame(0, 1, 0, 0, 64);
    finish_frame(0, 36);
    random_weights(0);
    fork
      frame(0, 2, 0, 0, 64);
      begin
        repeat (30) @(negedge clk);
        ordy[0] = 0;
        repeat (5) @(negedge clk);
        ordy[0] = 1;
      end
    join
    finish_frame(0, 36);
    random_weights(1);
    frame(1, 3, 0, 0, 64);
    finish_frame(1, 9);
    frame(0, 2, 0, 0, 30);
    rst = 1;
    #1;
    chk("midframe_reset_ready", rdy[0], 0);
    @(negedge clk);
    rst = 0;
    q0.delete();
    pres[0] = 0;
    #1;
    chk("post_reset_ready", rdy[0], 1);
    chk("post_reset_state", dst[0], 0);
    chk("post_reset_col", dcol[0], 0);
    chk("post_reset_valid", ov[0], 0);
    @(negedge clk);
    frame(0, 3, 0, 0, 64);
    finish_frame(0, 36);
    frame(0, 2, 30, 1, 64);
    finish_frame(0, 36);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
